btn_conditioner: RTL and testbench

- Upstream front-end for the simple calculator. Conditions the nine raw push-buttons B1..B9 (four digit-increment, four operations, one recall) into clean, single-cycle, clk-synchronous pulses.
- The calculator core consumes these pulses instead of using raw buttons as edge clocks.
- Per button: 2-flop synchronizer, consecutive-sample debounce counter, stable-level register, rising-edge pulse generator.

---
 rtl/btn_conditioner.sv | 151 +++++++++++++++
 tb/tb_btn_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns raw, bouncing, asynchronous push-button levels into clean single-cycle
// clk-synchronous pulses for the calculator core. Each channel has a 2-flop
// synchronizer, a consecutive-sample debounce counter, a stable-level register
// and a rising-edge pulse generator.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): channels selected by REPEAT_MASK
// emit repeat pulses while held, first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles. With the macro undefined, one pulse per press.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn_raw    raw button levels, 1 = pressed (asynchronous, bouncing)
//   btn_level  debounced stable level per button
//   btn_pulse  one-cycle pulse per accepted press (and per repeat if enabled)
//   any_pulse  OR of btn_pulse, registered alongside it
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int                 NUM_BTN         = 9,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_PERIOD   = 10000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 9'b000001111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] r_s1;
  logic [NUM_BTN-1:0] r_s2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_pulse;
  logic               r_any;
  logic [CW-1:0]      r_cnt [NUM_BTN];

  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_pulse_nxt;
  logic [CW-1:0]      w_cnt_nxt [NUM_BTN];

  // Debounce: count consecutive cycles where the synchronized input disagrees
  // with the stable level; any agreeing cycle restarts the count.
  always_comb begin
    w_level_nxt = r_level;
    w_rise      = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_level_nxt[i] = r_s2[i];
        w_cnt_nxt[i]   = '0;
        // Only a 0->1 acceptance is a press; releases are silent.
        w_rise[i]      = r_s2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            HW      = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DLY_MAX = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_MAX = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0]      r_hold [NUM_BTN];
  logic [NUM_BTN-1:0] r_phase;      // 0: waiting for first repeat, 1: periodic
  logic [HW-1:0]      w_hold_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] w_phase_nxt;
  logic [NUM_BTN-1:0] w_rep;

  // Hold timer: gated by the next stable level so a release on this edge
  // suppresses any repeat that would otherwise fire.
  always_comb begin
    w_phase_nxt = '0;
    w_rep       = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_hold_nxt[i] = '0;
      if (!REPEAT_MASK[i]) begin
        w_hold_nxt[i] = '0;
      end else if (!w_level_nxt[i] || w_rise[i]) begin
        w_hold_nxt[i] = '0;
      end else if (!r_phase[i] && (r_hold[i] == DLY_MAX)) begin
        w_rep[i]       = 1'b1;
        w_phase_nxt[i] = 1'b1;
      end else if (r_phase[i] && (r_hold[i] == PER_MAX)) begin
        w_rep[i]       = 1'b1;
        w_phase_nxt[i] = 1'b1;
      end else begin
        w_hold_nxt[i]  = r_hold[i] + HW'(1);
        w_phase_nxt[i] = r_phase[i];
      end
    end
    w_pulse_nxt = w_rise | w_rep;
  end

  // Hold timer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_hold[i] <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      for (int i = 0; i < NUM_BTN; i++) r_hold[i] <= w_hold_nxt[i];
    end
  end
`else
  // Repeat configuration has no effect in this build.
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = (^REPEAT_MASK) ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  // Pulse only on accepted presses.
  always_comb begin
    w_pulse_nxt = w_rise;
  end
`endif

  // Synchronizer, debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_level <= '0;
      r_pulse <= '0;
      r_any   <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= btn_raw;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_any   <= |w_pulse_nxt;
      for (int i = 0; i < NUM_BTN; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign btn_level = r_level;
  assign btn_pulse = r_pulse;
  assign any_pulse = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int         NB    = 9;
  localparam int         D     = 4;
  localparam int         RD    = 10;
  localparam int         RP    = 3;
  localparam logic [8:0] RMASK = 9'b000001111;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  int n_checks;
  int n_pass;

  btn_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(RMASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: synchronizer as a 2-sample delay, debounce as "the last D
  // synchronized samples all disagree with the level", repeats by arithmetic
  // on the number of cycles held since the press.
  logic [NB-1:0] m_s1, m_s2, m_level, m_pulse;
  logic          m_any;
  logic [NB-1:0] m_hist [D];
  int            m_held [NB];

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_any = 1'b0;
    for (int k = 0; k < D; k++) m_hist[k] = '0;
    for (int c = 0; c < NB; c++) m_held[c] = 0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] new_level;
    logic          all_diff;
    if (!rst) begin
      model_clear();
    end else begin
      for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      new_level = m_level;
      for (int c = 0; c < NB; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (m_hist[k][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) new_level[c] = ~m_level[c];
      end
      m_pulse = new_level & ~m_level;
`ifdef BTN_AUTOREPEAT_EN
      for (int c = 0; c < NB; c++) begin
        if (!new_level[c] || m_pulse[c]) begin
          m_held[c] = 0;
        end else begin
          m_held[c]++;
          if (RMASK[c] && m_held[c] >= RD && ((m_held[c] - RD) % RP) == 0) m_pulse[c] = 1'b1;
        end
      end
`endif
      m_level = new_level;
      m_any   = |m_pulse;
      m_s2    = m_s1;
      m_s1    = btn_raw;
    end
  endtask

  // Apply inputs, advance one clock edge, update the model, sample 1 ns later.
  task automatic step(input logic [NB-1:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step('0);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== 19'd0) begin
        $display("FAIL reset_hold cyc=%0d got lvl=%b pls=%b any=%b want all 0", j, btn_level, btn_pulse, any_pulse);
      end else n_pass++;
    end
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step('0);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== 19'd0) begin
        $display("FAIL reset_release cyc=%0d got lvl=%b pls=%b any=%b want all 0", j, btn_level, btn_pulse, any_pulse);
      end else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    for (int j = 0; j < 20; j++) begin
      step(9'b000000001);
      n_checks++;
      if (btn_pulse[0] !== (j == 5) || btn_level[0] !== (j >= 5) || any_pulse !== (j == 5)) begin
        $display("FAIL clean_press cyc=%0d got lvl=%b pls=%b any=%b want pls=%0d lvl=%0d",
                 j, btn_level[0], btn_pulse[0], any_pulse, (j == 5), (j >= 5));
      end else n_pass++;
    end
    for (int j = 0; j < 10; j++) begin
      step('0);
      n_checks++;
      if (btn_pulse !== 9'd0 || btn_level[0] !== (j < 5)) begin
        $display("FAIL clean_release cyc=%0d got pls=%b lvl=%b want pls=0 lvl=%0d", j, btn_pulse, btn_level[0], (j < 5));
      end else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [NB-1:0] raw;
    for (int j = 0; j < 20; j++) begin
      raw = '0;
      raw[4] = (j < 5) ? ((j % 2) == 0) : 1'b1;
      step(raw);
      n_checks++;
      if (btn_pulse[4] !== (j == 9) || {btn_level, btn_pulse, any_pulse} !== {m_level, m_pulse, m_any}) begin
        $display("FAIL bounce_press cyc=%0d got lvl=%b pls=%b want lvl=%b pls=%b",
                 j, btn_level, btn_pulse, m_level, m_pulse);
      end else n_pass++;
    end
    for (int j = 0; j < 15; j++) begin
      raw = '0;
      raw[4] = (j < 4) ? ((j % 2) == 1) : 1'b0;
      step(raw);
      n_checks++;
      if (btn_pulse !== 9'd0 || btn_level[4] !== (j < 9)) begin
        $display("FAIL bounce_release cyc=%0d got pls=%b lvl=%b want pls=0 lvl=%0d", j, btn_pulse, btn_level[4], (j < 9));
      end else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] exp_p;
    for (int j = 0; j < 15; j++) begin
      step(9'b001000010);
      exp_p = (j == 5) ? 9'b001000010 : 9'b000000000;
      n_checks++;
      if (btn_pulse !== exp_p || any_pulse !== (j == 5)) begin
        $display("FAIL simultaneous cyc=%0d got pls=%b any=%b want pls=%b any=%0d", j, btn_pulse, any_pulse, exp_p, (j == 5));
      end else n_pass++;
    end
    for (int j = 0; j < 10; j++) begin
      step('0);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== {m_level, m_pulse, m_any}) begin
        $display("FAIL simultaneous_release cyc=%0d got lvl=%b pls=%b want lvl=%b pls=%b", j, btn_level, btn_pulse, m_level, m_pulse);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 4; j++) step(9'b000000100);
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({btn_level, btn_pulse, any_pulse} !== 19'd0) begin
      $display("FAIL reset_mid_async got lvl=%b pls=%b any=%b want all 0", btn_level, btn_pulse, any_pulse);
    end else n_pass++;
    for (int j = 0; j < 2; j++) begin
      step(9'b000000100);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== 19'd0) begin
        $display("FAIL reset_mid_hold cyc=%0d got lvl=%b pls=%b any=%b want all 0", j, btn_level, btn_pulse, any_pulse);
      end else n_pass++;
    end
    rst = 1'b1;
    for (int j = 0; j < 15; j++) begin
      step(9'b000000100);
      n_checks++;
      if (btn_pulse[2] !== (j == 5) || btn_level[2] !== (j >= 5)) begin
        $display("FAIL reset_mid_requal cyc=%0d got pls=%b lvl=%b want pls=%0d lvl=%0d", j, btn_pulse[2], btn_level[2], (j == 5), (j >= 5));
      end else n_pass++;
    end
    for (int j = 0; j < 10; j++) step('0);
  endtask

  task automatic test_random();
    logic [NB-1:0] val;
    int            left [NB];
    val = '0;
    for (int c = 0; c < NB; c++) left[c] = $urandom_range(12, 1);
    for (int j = 0; j < 400; j++) begin
      for (int c = 0; c < NB; c++) begin
        left[c]--;
        if (left[c] == 0) begin
          val[c]  = ~val[c];
          left[c] = $urandom_range(12, 1);
        end
      end
      step(val);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== {m_level, m_pulse, m_any}) begin
        $display("FAIL random cyc=%0d got lvl=%b pls=%b any=%b want lvl=%b pls=%b any=%b",
                 j, btn_level, btn_pulse, any_pulse, m_level, m_pulse, m_any);
      end else n_pass++;
    end
    for (int j = 0; j < 10; j++) begin
      step('0);
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== {m_level, m_pulse, m_any}) begin
        $display("FAIL random_drain cyc=%0d got lvl=%b pls=%b want lvl=%b pls=%b", j, btn_level, btn_pulse, m_level, m_pulse);
      end else n_pass++;
    end
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat(input int ch, input int want_pulses);
    logic [NB-1:0] raw;
    int            seen;
    seen = 0;
    for (int j = 0; j < 45; j++) begin
      raw = '0;
      raw[ch] = (j < 30);
      step(raw);
      if (btn_pulse[ch] === 1'b1) seen++;
      n_checks++;
      if ({btn_level, btn_pulse, any_pulse} !== {m_level, m_pulse, m_any}) begin
        $display("FAIL autorepeat ch=%0d cyc=%0d got lvl=%b pls=%b any=%b want lvl=%b pls=%b any=%b",
                 ch, j, btn_level, btn_pulse, any_pulse, m_level, m_pulse, m_any);
      end else n_pass++;
    end
    n_checks++;
    if (seen != want_pulses) begin
      $display("FAIL autorepeat_count ch=%0d got %0d pulses want %0d", ch, seen, want_pulses);
    end else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    btn_raw  = '0;
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat(0, 8);
    test_autorepeat(5, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
